// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared state encoding, RGB565 layout and framebuffer addressing
package cam_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_FRAME   = 2'd2
    } cam_state_t;

    localparam int RGB_B_W   = 5;
    localparam int RGB_G_W   = 6;
    localparam int RGB_R_W   = 5;
    localparam int RGB_B_LSB = 0;
    localparam int RGB_G_LSB = RGB_B_LSB + RGB_B_W;
    localparam int RGB_R_LSB = RGB_G_LSB + RGB_G_W;
    localparam int PIX_W     = RGB_R_LSB + RGB_R_W;

    typedef struct packed {
        logic [RGB_R_W-1:0] r;
        logic [RGB_G_W-1:0] g;
        logic [RGB_B_W-1:0] b;
    } rgb565_t;

    // Linear address of a decimated pixel after optional mirroring.
    function automatic int unsigned fb_addr(
        input int unsigned x,
        input int unsigned y,
        input logic        mx,
        input logic        my,
        input int unsigned fb_w,
        input int unsigned fb_h
    );
        int unsigned xm;
        int unsigned ym;
        xm = mx ? (fb_w - 1 - x) : x;
        ym = my ? (fb_h - 1 - y) : y;
        return ym * fb_w + xm;
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - multi-flop synchroniser with rise/fall detection
module cam_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_q    = r_chain[STAGES-1];
    assign o_rise = r_chain[STAGES-1] & ~r_prev;
    assign o_fall = ~r_chain[STAGES-1] & r_prev;

endmodule

// File: rtl/cam_capture_scaler.sv
// rtl/cam_capture_scaler.sv - oversampled camera capture, decimation, crop, mirror and framebuffer writes
module cam_capture_scaler
    import cam_pkg::*;
#(
    parameter int SRC_W       = 640,
    parameter int SRC_H       = 480,
    parameter int SCALE_LOG2  = 2,
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int ADDR_W      = 15,
    parameter int BYTE_SWAP   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cam_pclk,
    input  logic              i_cam_href,
    input  logic              i_cam_vsync,
    input  logic [7:0]        i_cam_data,
    input  logic              i_enable,
    input  logic              i_mirror_x,
    input  logic              i_mirror_y,
    output logic              o_fb_we,
    output logic [ADDR_W-1:0] o_fb_waddr,
    output logic [PIX_W-1:0]  o_fb_wdata,
    output logic              o_frame_done,
    output logic [7:0]        o_frame_cnt,
    output logic              o_line_err,
    output logic              o_busy
);

    localparam int          COL_W    = $clog2(SRC_W + 1);
    localparam int          ROW_W    = $clog2(SRC_H + 1);
    localparam logic [31:0] DEC_MASK = (32'd1 << SCALE_LOG2) - 32'd1;

    logic w_pclk_q, w_pclk_rise, w_pclk_fall;
    logic w_href_q, w_href_rise, w_href_fall;
    logic w_vs_q, w_vs_rise, w_vs_fall;
    logic w_unused;

    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_cam_pclk),
        .o_q(w_pclk_q), .o_rise(w_pclk_rise), .o_fall(w_pclk_fall)
    );
    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_cam_href),
        .o_q(w_href_q), .o_rise(w_href_rise), .o_fall(w_href_fall)
    );
    cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
        .i_clk(i_clk), .i_reset(i_reset), .i_d(i_cam_vsync),
        .o_q(w_vs_q), .o_rise(w_vs_rise), .o_fall(w_vs_fall)
    );

    assign w_unused = w_pclk_q & w_pclk_fall & w_href_rise & w_vs_q;

    // Data gets the same depth as pclk so a synchronised rise sees the byte it carried.
    logic [7:0] r_data_sync [SYNC_STAGES];
    logic [7:0] w_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_data_sync[i] <= '0;
        end else begin
            r_data_sync[0] <= i_cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) r_data_sync[i] <= r_data_sync[i-1];
        end
    end

    assign w_data = r_data_sync[SYNC_STAGES-1];

    cam_state_t         r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_phase;
    logic [7:0]         r_byte0;
    logic               r_mx, r_my;
    logic               r_a_valid;
    rgb565_t            r_a_pix;
    logic [31:0]        r_a_x, r_a_y;
    logic               r_done_s1, r_done_s2;

    logic [31:0] w_col32, w_row32, w_x, w_y;
    logic        w_keep;
    rgb565_t     w_pix;

    assign w_col32 = 32'(r_col);
    assign w_row32 = 32'(r_row);
    assign w_x     = w_col32 >> SCALE_LOG2;
    assign w_y     = w_row32 >> SCALE_LOG2;
    assign w_keep  = ((w_col32 & DEC_MASK) == 32'd0) && ((w_row32 & DEC_MASK) == 32'd0)
                  && (w_x < FB_W) && (w_y < FB_H);
    assign w_pix   = (BYTE_SWAP != 0) ? {w_data, r_byte0} : {r_byte0, w_data};

    // frame_done is delayed two cycles so it always lands after a pixel captured alongside the vsync rise.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_phase      <= 1'b0;
            r_byte0      <= '0;
            r_mx         <= 1'b0;
            r_my         <= 1'b0;
            r_a_valid    <= 1'b0;
            r_a_pix      <= '0;
            r_a_x        <= '0;
            r_a_y        <= '0;
            r_done_s1    <= 1'b0;
            r_done_s2    <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= '0;
            o_line_err   <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            r_a_valid    <= 1'b0;
            r_done_s1    <= 1'b0;
            r_done_s2    <= r_done_s1;
            o_frame_done <= r_done_s2;
            if (r_done_s2) o_frame_cnt <= o_frame_cnt + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (i_enable) r_state <= S_WAIT_VS;
                end
                S_WAIT_VS: begin
                    if (w_vs_fall) begin
                        r_state <= S_FRAME;
                        o_busy  <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_phase <= 1'b0;
                        r_mx    <= i_mirror_x;
                        r_my    <= i_mirror_y;
                    end
                end
                S_FRAME: begin
                    if (w_pclk_rise && w_href_q) begin
                        if (!r_phase) begin
                            r_byte0 <= w_data;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase   <= 1'b0;
                            r_a_valid <= w_keep;
                            r_a_pix   <= w_pix;
                            r_a_x     <= w_x;
                            r_a_y     <= w_y;
                            if (w_col32 < SRC_W) r_col <= r_col + COL_W'(1);
                        end
                    end
                    if (w_href_fall) begin
                        if (w_row32 < SRC_H) r_row <= r_row + ROW_W'(1);
                        r_col   <= '0;
                        r_phase <= 1'b0;
                        if (r_phase) o_line_err <= 1'b1;
                    end
                    if (w_vs_rise) begin
                        r_done_s1 <= 1'b1;
                        o_busy    <= 1'b0;
                        r_state   <= i_enable ? S_WAIT_VS : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_fb_we    <= 1'b0;
            o_fb_waddr <= '0;
            o_fb_wdata <= '0;
        end else begin
            o_fb_we <= r_a_valid;
            if (r_a_valid) begin
                o_fb_waddr <= ADDR_W'(fb_addr(r_a_x, r_a_y, r_mx, r_my, $unsigned(FB_W), $unsigned(FB_H)));
                o_fb_wdata <= r_a_pix;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_scaler.sv
// tb/tb_cam_capture_scaler.sv - randomized scoreboard bench for cam_capture_scaler
module tb_cam_capture_scaler;

    localparam int SRC_W       = 8;
    localparam int SRC_H       = 4;
    localparam int SCALE_LOG2  = 1;
    localparam int FB_W        = 4;
    localparam int FB_H        = 2;
    localparam int ADDR_W      = 4;
    localparam int BYTE_SWAP   = 0;
    localparam int SYNC_STAGES = 2;
    localparam int DEC         = 1 << SCALE_LOG2;

    logic              clk = 1'b0;
    logic              rst;
    logic              cam_pclk, cam_href, cam_vsync;
    logic [7:0]        cam_data;
    logic              enable, mirror_x, mirror_y;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;
    logic [15:0]       fb_wdata;
    logic              frame_done;
    logic [7:0]        frame_cnt;
    logic              line_err, busy;

    cam_capture_scaler #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_LOG2(SCALE_LOG2), .FB_W(FB_W), .FB_H(FB_H),
        .ADDR_W(ADDR_W), .BYTE_SWAP(BYTE_SWAP), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_cam_pclk(cam_pclk), .i_cam_href(cam_href),
        .i_cam_vsync(cam_vsync), .i_cam_data(cam_data), .i_enable(enable),
        .i_mirror_x(mirror_x), .i_mirror_y(mirror_y), .o_fb_we(fb_we), .o_fb_waddr(fb_waddr),
        .o_fb_wdata(fb_wdata), .o_frame_done(frame_done), .o_frame_cnt(frame_cnt),
        .o_line_err(line_err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [15:0] data;
        int          due;
    } wr_t;

    wr_t  wq[$];
    int   dq[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_fcnt = 0;
    int   line_len[8];
    bit   prev_we = 1'b0;
    wr_t  mon_e;
    int   mon_f;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we) begin
                chk("we_not_back_to_back", 32'(prev_we), 0);
                chk("write_was_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    mon_e = wq.pop_front();
                    chk("fb_waddr", 32'(fb_waddr), mon_e.addr);
                    chk("fb_wdata", 32'(fb_wdata), 32'(mon_e.data));
                    chk("write_latency_cycle", cyc, mon_e.due);
                end
            end
            if (frame_done) begin
                chk("frame_done_expected", 32'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    mon_f = dq.pop_front();
                    chk("frame_cnt_at_done", 32'(frame_cnt), mon_f);
                    chk("writes_before_done", wq.size(), 0);
                end
            end
        end
        prev_we = fb_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_expired cycles=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic pclk_cycle(input logic [7:0] b, output int rc);
        @(negedge clk);
        cam_data = b;
        cam_pclk = 1'b0;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b1;
        rc = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_pixel(input int col, input int row, input logic [7:0] b0, input logic [7:0] b1,
                                input int rc, input bit mx, input bit my);
        wr_t e;
        int  x, y;
        if ((col % DEC) == 0 && (row % DEC) == 0) begin
            x = col / DEC;
            y = row / DEC;
            if (x < FB_W && y < FB_H) begin
                e.addr = (my ? FB_H - 1 - y : y) * FB_W + (mx ? FB_W - 1 - x : x);
                e.data = (BYTE_SWAP != 0) ? {b1, b0} : {b0, b1};
                e.due  = rc + SYNC_STAGES + 2;
                wq.push_back(e);
            end
        end
    endtask

    // mode 0: pixel = {row,col}; mode 1: random; mode 2: random with 0xAB,0xCD leading line 0
    task automatic send_line(input bit cap, input int l, input int nb, input int mode, input bit mx, input bit my);
        int          row, col, rc;
        logic [7:0]  b, b0;
        row = (l < SRC_H) ? l : SRC_H;
        b0  = 8'h00;
        @(negedge clk);
        cam_href = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            col = (i / 2 < SRC_W) ? i / 2 : SRC_W;
            if (mode == 0)                 b = (i % 2 == 0) ? 8'(row) : 8'(i / 2);
            else if (mode == 2 && l == 0 && i == 0) b = 8'hAB;
            else if (mode == 2 && l == 0 && i == 1) b = 8'hCD;
            else                           b = 8'($urandom_range(0, 255));
            pclk_cycle(b, rc);
            if (i % 2 == 0) b0 = b;
            else if (cap) expect_pixel(col, row, b0, b, rc, mx, my);
        end
        @(negedge clk);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input bit cap, input bit mx, input bit my, input int nlines, input int mode,
                             input bit toggle_mirror, input int drop_en_after);
        cam_vsync = 1'b1;
        mirror_x  = mx;
        mirror_y  = my;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_in_frame", 32'(busy), 32'(cap));
        for (int l = 0; l < nlines; l++) begin
            send_line(cap, l, line_len[l], mode, mx, my);
            if (toggle_mirror && l == 0) begin
                mirror_x = ~mx;
                mirror_y = ~my;
            end
            if (l == drop_en_after) enable = 1'b0;
        end
        cam_vsync = 1'b1;
        if (cap) begin
            exp_fcnt++;
            dq.push_back(exp_fcnt % 256);
        end
        repeat (10) @(negedge clk);
        chk("busy_after_frame", 32'(busy), 0);
    endtask

    task automatic reset_mid_frame();
        int         rc;
        logic [7:0] b, b0;
        b0 = 8'h00;
        cam_vsync = 1'b1;
        mirror_x  = 1'b0;
        mirror_y  = 1'b0;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        cam_href = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            b = (i % 2 == 0) ? 8'd0 : 8'(i / 2);
            pclk_cycle(b, rc);
            if (i % 2 == 0) b0 = b;
            else expect_pixel(i / 2, 0, b0, b, rc, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_outputs", {fb_we, fb_waddr, fb_wdata, frame_done, frame_cnt, line_err, busy}, 0);
        chk("writes_before_reset", wq.size(), 0);
        wq.delete();
        dq.delete();
        exp_fcnt = 0;
        for (int i = 10; i < 16; i++) begin
            pclk_cycle(8'(i), rc);
            if (i == 12) rst = 1'b0;
        end
        @(negedge clk);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
        for (int l = 1; l < 4; l++) send_line(1'b0, l, 16, 1, 1'b0, 1'b0);
        cam_vsync = 1'b1;
        repeat (10) @(negedge clk);
        chk("frame_cnt_after_abort", 32'(frame_cnt), 0);
        chk("busy_after_abort", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1;
        cam_data = 8'h00; mirror_x = 1'b0; mirror_y = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", {fb_we, fb_waddr, fb_wdata, frame_done, frame_cnt, line_err, busy}, 0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);

        for (int l = 0; l < 8; l++) line_len[l] = 16;
        run_frame(1'b1, 1'b0, 1'b0, 4, 0, 1'b0, -1);
        chk("frame_cnt_after_basic", 32'(frame_cnt), 1);
        chk("line_err_clean", 32'(line_err), 0);

        run_frame(1'b1, 1'b1, 1'b1, 4, 1, 1'b1, -1);
        run_frame(1'b1, 1'b0, 1'b1, 4, 2, 1'b0, -1);

        for (int l = 0; l < 8; l++) line_len[l] = 24;
        line_len[0] = 15;
        run_frame(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6, 1, 1'b0, -1);
        chk("line_err_set", 32'(line_err), 1);
        for (int l = 0; l < 8; l++) line_len[l] = 16;
        run_frame(1'b1, 1'b0, 1'b0, 4, 1, 1'b0, -1);
        chk("line_err_sticky", 32'(line_err), 1);

        reset_mid_frame();
        run_frame(1'b1, 1'b0, 1'b0, 4, 0, 1'b0, -1);
        chk("frame_cnt_after_reset_frame", 32'(frame_cnt), 1);

        run_frame(1'b1, 1'b0, 1'b0, 4, 1, 1'b0, 1);
        run_frame(1'b0, 1'b0, 1'b0, 4, 1, 1'b0, -1);
        chk("frame_cnt_after_disabled", 32'(frame_cnt), 2);

        enable = 1'b1;
        repeat (4) @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            int nl;
            nl = $urandom_range(4, 6);
            for (int l = 0; l < 8; l++) line_len[l] = 2 * $urandom_range(6, 12);
            run_frame(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nl, 1,
                      1'($urandom_range(0, 1)), -1);
        end
        chk("frame_cnt_final", 32'(frame_cnt), 32'(exp_fcnt % 256));

        repeat (20) @(negedge clk);
        chk("write_queue_drained", wq.size(), 0);
        chk("done_queue_drained", dq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
